// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
// Module   : pipeline_sequencer_if
// Purpose  : Hazard/memory status inputs and latch-control outputs of the
//            pipeline stall/flush sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dmem_req;
    logic             dhit;
    logic             hz_stall;
    logic             hz_flush;
    logic             halt_mem;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halt;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline/hazard side: supplies status, consumes controls.
    modport master (
        output ihit, dmem_req, dhit, hz_stall, hz_flush, halt_mem,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, halt, mem_err, state, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  ihit, dmem_req, dhit, hz_stall, hz_flush, halt_mem,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, halt, mem_err, state, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Central stall/flush sequencer for the 5-stage pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pipeline_sequencer_if.slave  bus
);

    localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int c_TO_W    = $clog2(MEM_TIMEOUT + 1);

    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_TO_W-1:0]    c_TO_MAX     = c_TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]     c_CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DRAIN_W-1:0] r_drain;
    logic [c_DRAIN_W-1:0] w_drain_nxt;
    logic [c_TO_W-1:0]    r_to;
    logic [c_TO_W-1:0]    w_to_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [CNT_W-1:0]     r_stall;
    logic [CNT_W-1:0]     w_stall_nxt;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_drain <= '0;
            r_to    <= '0;
            r_err   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_to    <= w_to_nxt;
            r_err   <= w_err_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain;
        w_to_nxt     = r_to;
        w_err_nxt    = r_err;
        w_stall_nxt  = r_stall;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_en    = 1'b0;
        w_exmem_en   = 1'b0;
        w_memwb_en   = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;

        if (!rst) begin
            case (r_state)
                S_RUN, S_MEMWAIT: begin
                    if (bus.dmem_req && !bus.dhit) begin
                        // Whole pipe freezes; only waits spent inside MEMWAIT count toward the timeout.
                        w_state_nxt = S_MEMWAIT;
                        if (r_state == S_MEMWAIT && r_to != c_TO_MAX) begin
                            w_to_nxt = r_to + c_TO_W'(1);
                            if (w_to_nxt == c_TO_MAX) begin
                                w_err_nxt = 1'b1;
                            end
                        end
                    end else begin
                        w_state_nxt = S_RUN;
                        w_to_nxt    = '0;
                        if (bus.halt_mem) begin
                            w_memwb_en  = 1'b1;
                            w_state_nxt = S_DRAIN;
                            w_drain_nxt = c_DRAIN_LOAD;
                        end else if (bus.hz_flush) begin
                            // Redirect wins over a pending fetch; the abandoned fetch is discarded.
                            w_pc_en      = 1'b1;
                            w_ifid_en    = 1'b1;
                            w_idex_en    = 1'b1;
                            w_exmem_en   = 1'b1;
                            w_memwb_en   = 1'b1;
                            w_ifid_flush = 1'b1;
                            w_idex_flush = 1'b1;
                        end else if (bus.hz_stall) begin
                            w_idex_en    = 1'b1;
                            w_exmem_en   = 1'b1;
                            w_memwb_en   = 1'b1;
                            w_idex_flush = 1'b1;
                        end else if (!bus.ihit) begin
                            w_ifid_en    = 1'b1;
                            w_idex_en    = 1'b1;
                            w_exmem_en   = 1'b1;
                            w_memwb_en   = 1'b1;
                            w_ifid_flush = 1'b1;
                        end else begin
                            w_pc_en    = 1'b1;
                            w_ifid_en  = 1'b1;
                            w_idex_en  = 1'b1;
                            w_exmem_en = 1'b1;
                            w_memwb_en = 1'b1;
                        end
                    end

                    if (!w_pc_en && r_stall != c_CNT_MAX) begin
                        w_stall_nxt = r_stall + CNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    w_memwb_en = 1'b1;
                    if (r_drain == '0) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_drain_nxt = r_drain - c_DRAIN_W'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.ifid_en    = w_ifid_en;
    assign bus.idex_en    = w_idex_en;
    assign bus.exmem_en   = w_exmem_en;
    assign bus.memwb_en   = w_memwb_en;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_flush = w_idex_flush;
    assign bus.halt       = (r_state == S_HALTED);
    assign bus.mem_err    = r_err;
    assign bus.state      = r_state;
    assign bus.stall_cnt  = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Directed and random checking of pipeline_sequencer against a model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

    localparam int D    = 2;
    localparam int MT   = 8;
    localparam int W    = 4;
    localparam int SMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_sequencer_if #(.CNT_W(W)) bus ();

    pipeline_sequencer #(
        .DRAIN_CYCLES (D),
        .MEM_TIMEOUT  (MT),
        .CNT_W        (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: 0 run, 1 waiting on data memory, 2 draining, 3 halted
    int m_state  = 0;
    int m_drain  = 0;
    int m_wait   = 0;
    int m_stalls = 0;
    bit m_err    = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare all outputs to the model, advance the model.
    task automatic step(input bit r, input bit ih, input bit dr, input bit dh,
                        input bit hs, input bit hf, input bit hm);
        bit [6:0]  en;
        bit [14:0] exp_v;
        bit [14:0] got_v;
        @(posedge clk);
        #1;
        rst          = r;
        bus.ihit     = ih;
        bus.dmem_req = dr;
        bus.dhit     = dh;
        bus.hz_stall = hs;
        bus.hz_flush = hf;
        bus.halt_mem = hm;
        #3;
        // en = {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
        if (r || m_state == 3)   en = 7'b0000000;
        else if (m_state == 2)   en = 7'b0000100;
        else if (dr && !dh)      en = 7'b0000000;
        else if (hm)             en = 7'b0000100;
        else if (hf)             en = 7'b1111111;
        else if (hs)             en = 7'b0011101;
        else if (!ih)            en = 7'b0111110;
        else                     en = 7'b1111100;

        exp_v = {en, (m_state == 3), m_err, 2'(m_state), 4'(m_stalls)};
        got_v = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                 bus.ifid_flush, bus.idex_flush, bus.halt, bus.mem_err,
                 bus.state, bus.stall_cnt};
        vectors++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs: got %b expected %b (pc,ifid,idex,exmem,memwb,iff,ixf,halt,err,state,cnt) t=%0t",
                     got_v, exp_v, $time);
        end

        if (r) begin
            m_state = 0; m_drain = 0; m_wait = 0; m_stalls = 0; m_err = 1'b0;
        end else if (m_state == 2) begin
            m_drain--;
            if (m_drain == 0) m_state = 3;
        end else if (m_state != 3) begin
            if (!en[6] && m_stalls < SMAX) m_stalls++;
            if (dr && !dh) begin
                if (m_state == 1 && m_wait < MT) begin
                    m_wait++;
                    if (m_wait == MT) m_err = 1'b1;
                end
                m_state = 1;
            end else begin
                m_wait = 0;
                if (hm) begin
                    m_state = 2;
                    m_drain = D;
                end else begin
                    m_state = 0;
                end
            end
        end
    endtask

    task automatic step_rand();
        step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(9) < 3,
             $urandom_range(1) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
             $urandom_range(99) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ihit = 1'b0; bus.dmem_req = 1'b0; bus.dhit = 1'b0;
        bus.hz_stall = 1'b0; bus.hz_flush = 1'b0; bus.halt_mem = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_state", bus.state, 0);
        chk("reset_stall_cnt", bus.stall_cnt, 0);

        // Load-use stall
        step(0, 1, 0, 0, 1, 0, 0);
        chk("ld_use_pc_en", bus.pc_en, 0);
        chk("ld_use_ifid_en", bus.ifid_en, 0);
        chk("ld_use_idex_flush", bus.idex_flush, 1);
        chk("ld_use_exmem_en", bus.exmem_en, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("ld_use_after_pc_en", bus.pc_en, 1);
        chk("ld_use_stall_cnt", bus.stall_cnt, 1);

        // Data memory wait of three cycles
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            chk("memwait_pc_en", bus.pc_en, 0);
        end
        step(0, 1, 1, 1, 0, 0, 0);
        chk("memwait_exit_state", bus.state, 1);
        chk("memwait_exit_memwb_en", bus.memwb_en, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("memwait_done_state", bus.state, 0);
        chk("memwait_stall_cnt", bus.stall_cnt, 3);

        // Flush beats stall and missing fetch
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("flush_pc_en", bus.pc_en, 1);
        chk("flush_ifid_flush", bus.ifid_flush, 1);
        chk("flush_idex_flush", bus.idex_flush, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("flush_stall_cnt", bus.stall_cnt, 0);

        // Memory timeout, sticky error
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MT + 1; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("timeout_not_yet", bus.mem_err, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("timeout_err", bus.mem_err, 1);
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("timeout_exit_state", bus.state, 0);
        chk("timeout_err_sticky", bus.mem_err, 1);

        // Stall counter saturation, then reset in the middle of a memory wait
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("stall_cnt_sat", bus.stall_cnt, 15);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("rst_mid_wait_pre", bus.state, 1);
        step(1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("rst_mid_wait_state", bus.state, 0);
        chk("rst_mid_wait_cnt", bus.stall_cnt, 0);
        chk("rst_mid_wait_err", bus.mem_err, 0);

        // Halt with two drain cycles, then inputs are ignored
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("halt_accept_memwb_en", bus.memwb_en, 1);
        chk("halt_accept_pc_en", bus.pc_en, 0);
        for (int i = 0; i < D; i++) begin
            step(0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), $urandom_range(1), $urandom_range(1));
            chk("drain_state", bus.state, 2);
            chk("drain_memwb_en", bus.memwb_en, 1);
            chk("drain_exmem_en", bus.exmem_en, 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, i[0], ~i[0], i[1], ~i[1], i[0], ~i[0]);
        end
        chk("halted_state", bus.state, 3);
        chk("halted_halt", bus.halt, 1);
        chk("halted_pc_en", bus.pc_en, 0);

        // Random traffic
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) step_rand();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
